// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC generation, credit-limited imem request channel, in-order response
// tagging, and a small output queue feeding the IF/ID register, with stall and redirect handling.
module instr_fetch_unit #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            out_valid,
    output logic [ILEN-1:0] instr_out,
    output logic [XLEN-1:0] PC_out,
    output logic [XLEN-1:0] PCPlus4_out
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0013);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] kill_q, kill_d;
    logic [CNT_W-1:0] qcount_q, qcount_d;
    logic [PTR_W-1:0] q_wptr_q, q_wptr_d;
    logic [PTR_W-1:0] q_rptr_q, q_rptr_d;
    logic [PTR_W-1:0] tag_wptr_q, tag_wptr_d;
    logic [PTR_W-1:0] tag_rptr_q, tag_rptr_d;

    logic [ILEN-1:0]  q_instr_q [QDEPTH];
    logic [ILEN-1:0]  q_instr_d [QDEPTH];
    logic [XLEN-1:0]  q_pc_q    [QDEPTH];
    logic [XLEN-1:0]  q_pc_d    [QDEPTH];
    logic [XLEN-1:0]  tag_pc_q  [QDEPTH];
    logic [XLEN-1:0]  tag_pc_d  [QDEPTH];

    logic credit_ok;
    logic accept;
    logic resp_fire;
    logic resp_keep;
    logic pop;
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Request channel and queue-head outputs; redirect and reset suppress both sides.
    always_comb begin
        credit_ok      = (SUM_W'(inflight_q) + SUM_W'(qcount_q)) < SUM_W'(QDEPTH);
        imem_req_valid = !reset && !redirect_valid && credit_ok;
        imem_req_addr  = fetch_pc_q;
        out_valid      = !reset && !redirect_valid && (qcount_q != '0);
        instr_out      = out_valid ? q_instr_q[q_rptr_q] : NOP;
        PC_out         = out_valid ? q_pc_q[q_rptr_q] : '0;
        PCPlus4_out    = out_valid ? (q_pc_q[q_rptr_q] + XLEN'(4)) : '0;
    end

    always_comb begin
        accept    = imem_req_valid && imem_req_ready;
        resp_fire = imem_resp_valid && (inflight_q != '0);
        resp_keep = resp_fire && (kill_q == '0) && !redirect_valid;
        pop       = out_valid && !stall;

        fetch_pc_d = fetch_pc_q;
        kill_d     = kill_q;
        q_wptr_d   = q_wptr_q;
        q_rptr_d   = q_rptr_q;
        tag_wptr_d = tag_wptr_q;
        tag_rptr_d = tag_rptr_q;
        q_instr_d  = q_instr_q;
        q_pc_d     = q_pc_q;
        tag_pc_d   = tag_pc_q;

        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(resp_fire);
        qcount_d   = qcount_q + CNT_W'(resp_keep) - CNT_W'(pop);

        if (accept) begin
            tag_pc_d[tag_wptr_q] = fetch_pc_q;
            tag_wptr_d           = tag_wptr_q + PTR_W'(1);
            fetch_pc_d           = fetch_pc_q + XLEN'(4);
        end

        // Every response retires its tag, whether it is kept or killed.
        if (resp_fire) begin
            tag_rptr_d = tag_rptr_q + PTR_W'(1);
            if (kill_q != '0) begin
                kill_d = kill_q - CNT_W'(1);
            end
        end

        if (resp_keep) begin
            q_instr_d[q_wptr_q] = imem_resp_instr;
            q_pc_d[q_wptr_q]    = tag_pc_q[tag_rptr_q];
            q_wptr_d            = q_wptr_q + PTR_W'(1);
        end

        if (pop) begin
            q_rptr_d = q_rptr_q + PTR_W'(1);
        end

        // Redirect: flush queue, retarget PC, kill whatever is still outstanding after this cycle.
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            qcount_d   = '0;
            q_wptr_d   = '0;
            q_rptr_d   = '0;
            kill_d     = inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            kill_q     <= '0;
            qcount_q   <= '0;
            q_wptr_q   <= '0;
            q_rptr_q   <= '0;
            tag_wptr_q <= '0;
            tag_rptr_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            qcount_q   <= qcount_d;
            q_wptr_q   <= q_wptr_d;
            q_rptr_q   <= q_rptr_d;
            tag_wptr_q <= tag_wptr_d;
            tag_rptr_q <= tag_rptr_d;
        end
    end

    // Payload storage needs no reset: it is only read behind the count/pointers.
    always_ff @(posedge clk) begin
        q_instr_q <= q_instr_d;
        q_pc_q    <= q_pc_d;
        tag_pc_q  <= tag_pc_d;
    end

    a_resp_has_request: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order variable-latency memory model plus a stream-level
// reference (consecutive PCs from reset/redirect target, instr = addr-derived word).
module tb_instr_fetch_unit;

    localparam int unsigned QD = 4;
    localparam logic [63:0] W_RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [63:0] imem_req_addr;
    logic [31:0] imem_resp_instr;
    logic        redirect_valid, stall, out_valid;
    logic [63:0] redirect_pc, PC_out, PCPlus4_out;
    logic [31:0] instr_out;

    logic        w_req_valid, w_ready, w_resp_valid, w_redirect, w_stall, w_out_valid;
    logic [63:0] w_req_addr, w_redirect_pc, w_pc, w_pc4;
    logic [31:0] w_resp_instr, w_instr;

    instr_fetch_unit #(.XLEN(64), .ILEN(32), .RESET_PC(64'h0), .QDEPTH(QD)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_instr(imem_resp_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .out_valid(out_valid), .instr_out(instr_out), .PC_out(PC_out), .PCPlus4_out(PCPlus4_out)
    );

    instr_fetch_unit #(.XLEN(64), .ILEN(32), .RESET_PC(W_RESET_PC), .QDEPTH(2)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_ready), .imem_req_addr(w_req_addr),
        .imem_resp_valid(w_resp_valid), .imem_resp_instr(w_resp_instr),
        .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc), .stall(w_stall),
        .out_valid(w_out_valid), .instr_out(w_instr), .PC_out(w_pc), .PCPlus4_out(w_pc4)
    );

    int          total, bad, cyc, n_acc, n_out, lat_min, lat_max, n0;
    req_t        pend[$];
    logic [63:0] exp_pc, w_exp_pc, w_fetch_exp, w_acc_addr;
    logic        w_acc, last_ov;
    logic [63:0] last_pc, last_pc4;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Sampled mid-cycle: compare against the stream model, then update memory bookkeeping.
    task automatic observe();
        last_ov  = out_valid;
        last_pc  = PC_out;
        last_pc4 = PCPlus4_out;
        if (reset) begin
            exp_pc      = 64'h0;
            w_exp_pc    = W_RESET_PC;
            w_fetch_exp = W_RESET_PC;
            w_acc       = 1'b0;
            pend.delete();
            return;
        end
        if (imem_req_valid) check("addr_align", 64'(imem_req_addr[1:0]), 64'h0);
        if (redirect_valid) begin
            check("redir_out_valid", 64'(out_valid), 64'h0);
            check("redir_req_valid", 64'(imem_req_valid), 64'h0);
            exp_pc = {redirect_pc[63:2], 2'b00};
        end else if (out_valid) begin
            check("pc", PC_out, exp_pc);
            check("pc4", PCPlus4_out, exp_pc + 64'd4);
            check("instr", 64'(instr_out), 64'(mem_word(exp_pc)));
            if (!stall) begin
                exp_pc = exp_pc + 64'd4;
                n_out++;
            end
        end
        if (imem_resp_valid) void'(pend.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{addr: imem_req_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
            n_acc++;
            check("outstanding_cap", 64'(pend.size() <= QD), 64'h1);
        end
        if (w_req_valid) begin
            check("w_req_addr", w_req_addr, w_fetch_exp);
            w_fetch_exp = w_fetch_exp + 64'd4;
        end
        if (w_out_valid) begin
            check("w_pc", w_pc, w_exp_pc);
            check("w_pc4", w_pc4, w_exp_pc + 64'd4);
            check("w_instr", 64'(w_instr), 64'(mem_word(w_exp_pc)));
            w_exp_pc = w_exp_pc + 64'd4;
        end
        w_acc      = w_req_valid;
        w_acc_addr = w_req_addr;
    endtask

    task automatic cycle();
        if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_instr = mem_word(pend[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_instr = '0;
        end
        w_resp_valid = w_acc && !reset;
        w_resp_instr = mem_word(w_acc_addr);
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_out(input string tag, input logic [63:0] pc);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle();
            seen = last_ov;
        end
        check({tag, "_seen"}, 64'(seen), 64'h1);
        if (seen) begin
            check({tag, "_pc"}, last_pc, pc);
            check({tag, "_pc4"}, last_pc4, pc + 64'd4);
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; n_acc = 0; n_out = 0; lat_min = 1; lat_max = 1;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b1;
        w_ready = 1'b1; w_redirect = 1'b0; w_redirect_pc = '0; w_stall = 1'b0;
        w_acc = 1'b0; w_acc_addr = '0; exp_pc = '0; w_exp_pc = W_RESET_PC; w_fetch_exp = W_RESET_PC;

        // Reset state
        cycle();
        cycle();
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_instr", 64'(instr_out), 64'h13);
        check("rst_pc", PC_out, 64'h0);
        check("rst_pc4", PCPlus4_out, 64'h0);
        check("rst_req_valid", 64'(imem_req_valid), 64'h0);
        check("w_rst_pc", w_pc, 64'h0);

        // Streaming with 1-cycle memory: no bubbles once filled
        reset = 1'b0;
        #1;
        check("first_req_valid", 64'(imem_req_valid), 64'h1);
        check("first_req_addr", imem_req_addr, 64'h0);
        check("w_first_addr", w_req_addr, W_RESET_PC);
        cycle();
        cycle();
        for (int i = 0; i < 12; i++) begin
            cycle();
            check("t1_no_bubble", 64'(last_ov), 64'h1);
        end

        // Held stall: queue fills to depth, issue stops, then resumes without gap
        stall = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        check("t2_queued", 64'(n_acc - n_out), 64'(QD));
        check("t2_req_idle", 64'(imem_req_valid), 64'h0);
        check("t2_mem_idle", 64'(pend.size()), 64'h0);
        stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("t2_no_gap", 64'(last_ov), 64'h1);
        end

        // Reset mid-stream, then redirect with two requests in flight
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        lat_min = 5; lat_max = 5;
        for (int i = 0; i < 10 && pend.size() != 2; i++) cycle();
        check("t3_inflight", 64'(pend.size()), 64'h2);
        redirect_valid = 1'b1;
        redirect_pc = 64'h1002;
        cycle();
        redirect_valid = 1'b0;
        wait_out("t3", 64'h1000);

        // Redirect in a cycle that also carries a response and a pop
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 10; i++) cycle();
        redirect_valid = 1'b1;
        redirect_pc = 64'h2000;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        check("t4_ov_after", 64'(last_ov), 64'h0);
        wait_out("t4", 64'h2000);

        // Random ready/latency/stall/redirect
        lat_min = 1; lat_max = 5;
        n0 = n_out;
        for (int i = 0; i < 10000; i++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            stall = ($urandom_range(3, 0) == 0);
            redirect_valid = ($urandom_range(39, 0) == 0);
            redirect_pc = {$urandom(), $urandom()};
            cycle();
        end
        check("t6_progress", 64'((n_out - n0) > 1000), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
